// File: rtl/gate_pkg.sv
// Shared types for the serial gate blocks: gate opcodes and the deserializer FSM states.
package gate_pkg;

    typedef enum logic [1:0] {
        GATE_AND  = 2'b00,
        GATE_OR   = 2'b01,
        GATE_XOR  = 2'b10,
        GATE_NAND = 2'b11
    } gate_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } deser_state_e;

endpackage

// File: rtl/serial_gate8_deser_if.sv
// Control, serial-input and parallel-output handshake bundle of serial_gate8_deser.
interface serial_gate8_deser_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic             bit_valid;
    logic             bit_a;
    logic             bit_b;
    logic             bit_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    // The producer/consumer side drives the stream and the output ready.
    modport master (
        output start, op, bit_valid, bit_a, bit_b, out_ready,
        input  bit_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, op, bit_valid, bit_a, bit_b, out_ready,
        output bit_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/gate_sel_cell.sv
// Combinational 1-bit two-input gate with a 2-bit operation select.
module gate_sel_cell
    import gate_pkg::*;
(
    input  gate_op_e op,
    input  logic     a,
    input  logic     b,
    output logic     y
);

    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = 1'b0;
        case (op)
            GATE_AND:  y = a & b;
            GATE_OR:   y = a | b;
            GATE_XOR:  y = a ^ b;
            GATE_NAND: y = ~(a & b);
            default:   y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_gate8_deser.sv
// Bit-serial gate: applies a latched 2-input gate to LSB-first bit pairs and
// assembles the results into a WIDTH-bit word behind a valid/ready handshake.
module serial_gate8_deser
    import gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_gate8_deser_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    deser_state_e     state;
    gate_op_e         op_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] data_q;
    logic             res;

    gate_sel_cell u_gate (
        .op (op_q),
        .a  (bus.bit_a),
        .b  (bus.bit_b),
        .y  (res)
    );

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op_q   <= GATE_AND;
            cnt    <= '0;
            sr     <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= gate_op_e'(bus.op);
                        cnt   <= '0;
                        sr    <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.bit_valid) begin
                        // Result enters at the MSB so the first bit lands at bit 0 after WIDTH accepts.
                        sr  <= {res, sr[WIDTH-1:1]};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            data_q <= {res, sr[WIDTH-1:1]};
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bit_ready = (state == SHIFT);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_serial_gate8_deser.sv
// Self-checking bench for serial_gate8_deser against a word-level gate model.
module tb_serial_gate8_deser;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    serial_gate8_deser_if #(.WIDTH(W)) bus ();

    serial_gate8_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Whole-word reference: the gate applied to both operand words at once.
    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a word and streams all W bit pairs; returns cycles from start to DONE entry.
    // gap_mode: 0 continuous, 1 alternate valid/gap, 2 random gaps.
    task automatic feed_word(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int gap_mode, input bit disturb,
                             output int cyc, output bit ctl_ok, output bit hold_ok, output bit tmo);
        int i;
        bit v;
        logic [W-1:0] d0;
        cyc = 0; ctl_ok = 1'b1; hold_ok = 1'b1; tmo = 1'b0; i = 0;
        d0 = bus.out_data;
        bus.op = o;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        cyc = 1;
        while (i < W && !tmo) begin
            if (bus.bit_ready !== 1'b1 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) ctl_ok = 1'b0;
            if (bus.out_data !== d0) hold_ok = 1'b0;
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 1);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            bus.bit_valid = v;
            bus.bit_a = a[i];
            bus.bit_b = b[i];
            if (disturb && i == 3) begin
                bus.start = 1'b1;
                bus.op = 2'b11;
            end else begin
                bus.start = 1'b0;
            end
            tick;
            cyc++;
            if (v) i++;
            if (cyc > 200) tmo = 1'b1;
        end
        bus.bit_valid = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready: got %b expected 0", bus.bit_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        #9 rst_n = 1'b1;
        bus.bit_valid = 1'b1;
        tick;
        tick;
        checks++; if (bus.busy !== 1'b0 || bus.bit_ready !== 1'b0)
            begin errors++; $display("FAIL idle_ignores_bits: busy=%b bit_ready=%b expected 0 0", bus.busy, bus.bit_ready); end
        bus.bit_valid = 1'b0;
    endtask

    task automatic test_and_word;
        int cyc; bit ok, hold, tmo;
        bus.out_ready = 1'b1;
        feed_word(2'b00, 8'hF0, 8'hAA, 0, 1'b0, cyc, ok, hold, tmo);
        checks++; if (tmo) begin errors++; $display("FAIL and_timeout: word did not complete"); end
        checks++; if (!ok) begin errors++; $display("FAIL and_shift_ctl: bit_ready/busy/out_valid wrong during SHIFT"); end
        checks++; if (cyc !== 9) begin errors++; $display("FAIL and_latency: got %0d expected 9", cyc); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL and_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.out_data !== 8'hA0) begin errors++; $display("FAIL and_data: got %h expected a0", bus.out_data); end
        tick;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL and_one_cycle_valid: out_valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_ops;
        int cyc; bit ok, hold, tmo;
        logic [W-1:0] exp_v [3] = '{8'h3F, 8'h33, 8'hF3};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            feed_word(2'(k + 1), 8'h3C, 8'h0F, 0, 1'b0, cyc, ok, hold, tmo);
            checks++; if (tmo || bus.out_data !== exp_v[k])
                begin errors++; $display("FAIL op_%0d_data: got %h expected %h", k + 1, bus.out_data, exp_v[k]); end
            tick;
        end
    endtask

    task automatic test_stall_backpressure;
        int cyc; bit ok, hold, tmo;
        logic [W-1:0] a, b, exp;
        a = W'($urandom); b = W'($urandom);
        exp = model(2'b01, a, b);
        bus.out_ready = 1'b0;
        feed_word(2'b01, a, b, 1, 1'b0, cyc, ok, hold, tmo);
        checks++; if (tmo || !ok) begin errors++; $display("FAIL stall_shift: tmo=%b ctl_ok=%b expected 0 1", tmo, ok); end
        checks++; if (cyc !== 16) begin errors++; $display("FAIL stall_latency: got %0d expected 16", cyc); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
            begin errors++; $display("FAIL stall_data: valid=%b data=%h expected 1 %h", bus.out_valid, bus.out_data, exp); end
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp || bus.busy !== 1'b1 || bus.bit_ready !== 1'b0)
                begin errors++; $display("FAIL backpressure_hold_%0d: valid=%b data=%h busy=%b bit_ready=%b expected 1 %h 1 0",
                                         k, bus.out_valid, bus.out_data, bus.busy, bus.bit_ready, exp); end
        end
        bus.out_ready = 1'b1;
        tick;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL backpressure_release: valid=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_ignored_controls;
        int cyc; bit ok, hold, tmo;
        bus.out_ready = 1'b1;
        feed_word(2'b00, 8'h3C, 8'h0F, 0, 1'b1, cyc, ok, hold, tmo);
        checks++; if (tmo || cyc !== 9 || !ok)
            begin errors++; $display("FAIL ignored_restart: cyc=%0d ctl_ok=%b expected 9 1", cyc, ok); end
        checks++; if (bus.out_data !== 8'h0C) begin errors++; $display("FAIL ignored_data: got %h expected 0c", bus.out_data); end
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_idle: busy=%b expected 0", bus.busy); end
        bus.op = 2'b00;
    endtask

    task automatic test_reset_mid_word;
        int cyc; bit ok, hold, tmo;
        bus.out_ready = 1'b1;
        bus.op = 2'b01;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.bit_valid = 1'b1; bus.bit_a = 1'b1; bus.bit_b = 1'b1;
        repeat (4) tick;
        rst_n = 1'b0;
        #2;
        checks++; if (bus.out_data !== '0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.bit_ready !== 1'b0)
            begin errors++; $display("FAIL midword_reset: data=%h busy=%b valid=%b bit_ready=%b expected 00 0 0 0",
                                     bus.out_data, bus.busy, bus.out_valid, bus.bit_ready); end
        bus.bit_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        feed_word(2'b10, 8'hFF, 8'h0F, 0, 1'b0, cyc, ok, hold, tmo);
        checks++; if (tmo || cyc !== 9 || bus.out_data !== 8'hF0)
            begin errors++; $display("FAIL midword_fresh: cyc=%0d data=%h expected 9 f0", cyc, bus.out_data); end
        tick;
    endtask

    task automatic test_back_to_back;
        int cyc; bit ok, hold, tmo;
        logic [W-1:0] a1, b1, a2, b2, e1, e2;
        logic [1:0] o1, o2;
        a1 = W'($urandom); b1 = W'($urandom); o1 = 2'($urandom_range(0, 3));
        a2 = W'($urandom); b2 = W'($urandom); o2 = 2'($urandom_range(0, 3));
        e1 = model(o1, a1, b1);
        e2 = model(o2, a2, b2);
        bus.out_ready = 1'b1;
        feed_word(o1, a1, b1, 0, 1'b0, cyc, ok, hold, tmo);
        checks++; if (tmo || bus.out_data !== e1) begin errors++; $display("FAIL b2b_first: got %h expected %h", bus.out_data, e1); end
        // start raised during the DONE->IDLE cycle must not be seen.
        bus.start = 1'b1;
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start: busy=%b expected 0", bus.busy); end
        feed_word(o2, a2, b2, 2, 1'b0, cyc, ok, hold, tmo);
        checks++; if (!hold) begin errors++; $display("FAIL b2b_hold: out_data changed before second DONE"); end
        checks++; if (tmo || !ok || bus.out_data !== e2)
            begin errors++; $display("FAIL b2b_second: got %h expected %h ctl_ok=%b", bus.out_data, e2, ok); end
        tick;
    endtask

    task automatic test_random;
        int cyc, d; bit ok, hold, tmo;
        logic [W-1:0] a, b, exp;
        logic [1:0] o;
        for (int n = 0; n < 20; n++) begin
            a = W'($urandom); b = W'($urandom); o = 2'($urandom_range(0, 3));
            exp = model(o, a, b);
            bus.out_ready = 1'b0;
            feed_word(o, a, b, 2, 1'b0, cyc, ok, hold, tmo);
            checks++; if (tmo || !ok || !hold || bus.out_valid !== 1'b1 || bus.out_data !== exp)
                begin errors++; $display("FAIL rand_%0d: op=%b data=%h expected %h valid=%b ctl_ok=%b hold=%b",
                                         n, o, bus.out_data, exp, bus.out_valid, ok, hold); end
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) tick;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp)
                begin errors++; $display("FAIL rand_%0d_wait: valid=%b data=%h expected 1 %h", n, bus.out_valid, bus.out_data, exp); end
            bus.out_ready = 1'b1;
            tick;
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rand_%0d_release: valid=%b expected 0", n, bus.out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.bit_valid = 1'b0;
        bus.bit_a = 1'b0; bus.bit_b = 1'b0; bus.out_ready = 1'b0;
        test_reset;
        test_and_word;
        test_ops;
        test_stall_backpressure;
        test_ignored_controls;
        test_reset_mid_word;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_gate8_deser.md
Name: serial_gate8_deser

Overview:
- Bit-serial counterpart of the parallel 8-bit gate library.
- Accepts two operand streams one bit per cycle, LSB first, and applies a selected 2-input gate to each bit pair.
- Assembles the per-bit results into a WIDTH-bit word and presents it on a valid/ready output handshake.
- Sits between a serial link and parallel consumers of gate results.

Parameters:
- WIDTH, 8: number of bit pairs per word; legal range 2..32.
- CW, $clog2(WIDTH): bit-counter width; derived, not to be overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a word; sampled only in IDLE
- op  in  2  gate select, latched with start: 00 AND, 01 OR, 10 XOR, 11 NAND
- bit_valid  in  1  bit_a/bit_b carry a valid pair this cycle
- bit_a  in  1  operand A serial bit
- bit_b  in  1  operand B serial bit
- bit_ready  out  1  block accepts a bit pair this cycle
- out_valid  out  1  out_data holds a complete word
- out_ready  in  1  consumer accepts out_data
- out_data  out  WIDTH  assembled result word
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by system):
  - state=IDLE, counter=0, shift register=0, latched op=00.
  - All outputs 0: out_data=0, out_valid=0, bit_ready=0, busy=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - bit_ready=0.
  - start=1 -> latch op, clear counter and shift register, go to SHIFT next cycle.
  - bit_valid is ignored.
- SHIFT:
  - bit_ready=1.
  - A bit pair is accepted when bit_valid=1.
  - On acceptance: result bit = gate(op_latched, bit_a, bit_b); shift register shifts right with the result bit entering the MSB, so the first bit ends at bit 0 after WIDTH accepts; counter increments.
  - Gaps (bit_valid=0) stall without state change; there is no timeout.
  - The accept with counter=WIDTH-1 -> go to DONE; out_data is updated from the shift register on the same edge.
- DONE:
  - out_valid=1, bit_ready=0; out_data stable.
  - out_ready=1 -> out_valid drops next cycle, state returns to IDLE.
- start outside IDLE is ignored; op changes after the start cycle have no effect.
- out_data holds its last value after the handshake until the next DONE entry. It is not cleared in IDLE.
- Latency: start at cycle 0. Word complete at the edge of the WIDTH-th accept. With continuous bit_valid from cycle 1, out_valid rises at cycle WIDTH+1.
- out_ready held high on DONE entry -> out_valid asserts for exactly 1 cycle.
- start in the same cycle as the DONE->IDLE transition is not seen. start is honoured from the first IDLE cycle.
- rst_n low mid-SHIFT or mid-DONE aborts the word; partial data is discarded and the reset values apply.
- No combinational path from inputs to outputs. bit_ready, out_valid and busy decode from registered state only.

Decomposition:
- Shared package gate_pkg:
  - op enum: GATE_AND=2'b00, GATE_OR=2'b01, GATE_XOR=2'b10, GATE_NAND=2'b11.
  - FSM state typedef: IDLE, SHIFT, DONE.
- One sub-module: gate_sel_cell, a combinational 1-bit gate with a 2-bit op select. It is reusable by other serial gate blocks.
- Counter, shift register and FSM stay in the top module.

Test Plan:
- AND word: op=00, A stream 8'hF0, B stream 8'hAA (LSB first), bit_valid continuous, out_ready=1 -> out_data=8'hA0, out_valid for 1 cycle at cycle 9 after start.
- Op coverage: A=8'h3C, B=8'h0F with op=01, 10 and 11 -> out_data=8'h3F, 8'h33 and 8'hF3 respectively.
- Stall and backpressure: bit_valid toggled 1/0 every cycle, out_ready held 0 for 5 cycles after out_valid -> correct data; out_valid and out_data stable across the stall; busy=1 throughout; bit_ready=0 in DONE.
- Ignored controls: start pulsed and op changed to 11 during SHIFT of an AND word -> result unaffected; no restart.
- Reset mid-word: rst_n low after 4 accepted bits, then a fresh start with XOR A=8'hFF, B=8'h0F -> out_data=8'hF0, no contamination from the aborted word; out_data=0 right after reset.
- Back-to-back: start in the first IDLE cycle after handshake -> second word correct; out_data keeps the first result until the second DONE.
